// File: rtl/operand_sequencer.sv
// Operand/result sequencer for the shared wide-operand datapath: byte-wise operand load,
// fixed-latency execute, byte-wise result drain. Optional checksum byte: OPERAND_SEQUENCER_CHECKSUM_EN.
module operand_sequencer #(
    parameter int LOG2_BYTES_IN  = 3,
    parameter int LOG2_BYTES_OUT = 2,
    parameter int LATENCY        = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [7:0]                      in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [(1<<LOG2_BYTES_IN)*8-1:0] op_data,
    output logic                            op_start,
    input  logic [(1<<LOG2_BYTES_OUT)*8-1:0] res_data,
    output logic [7:0]                      out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_last,
    output logic                            busy
);
    localparam int BYTES_IN  = 1 << LOG2_BYTES_IN;
    localparam int BYTES_OUT = 1 << LOG2_BYTES_OUT;
    localparam int IDX_W     = LOG2_BYTES_OUT + 1;
`ifdef OPERAND_SEQUENCER_CHECKSUM_EN
    localparam int LAST_IDX  = BYTES_OUT;
`else
    localparam int LAST_IDX  = BYTES_OUT - 1;
`endif

    localparam logic [1:0] LOAD  = 2'd0;
    localparam logic [1:0] EXEC  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]                 state;
    logic [LOG2_BYTES_IN-1:0]   cnt;
    logic [3:0]                 wait_cnt;
    logic [IDX_W-1:0]           idx;
    logic [BYTES_OUT*8-1:0]     shadow;
    logic [7:0]                 shadow_byte;

    assign in_ready  = (state == LOAD) && !reset;
    assign out_valid = (state == DRAIN);
    assign busy      = (state != LOAD);
    assign out_last  = (state == DRAIN) && (idx == IDX_W'(LAST_IDX));

    assign shadow_byte = shadow[{idx[LOG2_BYTES_OUT-1:0], 3'b000} +: 8];

`ifdef OPERAND_SEQUENCER_CHECKSUM_EN
    logic [7:0] checksum;

    always_comb begin
        checksum = 8'h00;
        for (int i = 0; i < BYTES_OUT; i++) begin
            checksum = checksum ^ shadow[i*8 +: 8];
        end
    end

    // The checksum occupies the slot just past the last result byte.
    assign out_data = (idx == IDX_W'(BYTES_OUT)) ? checksum : shadow_byte;
`else
    assign out_data = shadow_byte;
`endif

    // op_start is registered so it rises exactly in the first EXEC cycle and is clean out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= LOAD;
            cnt      <= '0;
            wait_cnt <= '0;
            idx      <= '0;
            op_data  <= '0;
            shadow   <= '0;
            op_start <= 1'b0;
        end else begin
            op_start <= 1'b0;
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        op_data[{cnt, 3'b000} +: 8] <= in_data;
                        cnt <= cnt + 1'b1;
                        if (cnt == LOG2_BYTES_IN'(BYTES_IN - 1)) begin
                            state    <= EXEC;
                            op_start <= 1'b1;
                            wait_cnt <= '0;
                        end
                    end
                end
                EXEC: begin
                    if (wait_cnt == 4'(LATENCY - 1)) begin
                        shadow   <= res_data;
                        wait_cnt <= '0;
                        state    <= DRAIN;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (idx == IDX_W'(LAST_IDX)) begin
                            idx   <= '0;
                            state <= LOAD;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_operand_sequencer.sv
// Self-checking bench for operand_sequencer: frame-level scoreboard model plus directed frames,
// backpressure, input gaps and mid-frame resets. Honours OPERAND_SEQUENCER_CHECKSUM_EN.
module tb_operand_sequencer;
    localparam int LAT = 3;
    localparam int BI  = 8;
    localparam int BO  = 4;
`ifdef OPERAND_SEQUENCER_CHECKSUM_EN
    localparam int N_OUT = BO + 1;
    localparam logic [39:0] EXP_BASIC = 40'h0404030201;
    localparam logic [39:0] EXP_BEEF  = 40'h22DEADBEEF;
    localparam logic [39:0] EXP_BP    = 40'h4444332211;
    localparam logic [39:0] EXP_GAP   = 40'hC050607080;
`else
    localparam int N_OUT = BO;
    localparam logic [39:0] EXP_BASIC = 40'h0004030201;
    localparam logic [39:0] EXP_BEEF  = 40'h00DEADBEEF;
    localparam logic [39:0] EXP_BP    = 40'h0044332211;
    localparam logic [39:0] EXP_GAP   = 40'h0050607080;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] op_data;
    logic        op_start;
    logic [31:0] res_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic        busy;

    int checks = 0;
    int failures = 0;

    operand_sequencer #(.LOG2_BYTES_IN(3), .LOG2_BYTES_OUT(2), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .op_data(op_data), .op_start(op_start), .res_data(res_data), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: the true result is visible only in the one cycle the sequencer must sample.
    logic [7:0] dp_age = 8'd0;
    always @(posedge clk) begin
        if (op_start) dp_age <= 8'd1;
        else if (dp_age != 8'd0 && dp_age != 8'hFF) dp_age <= dp_age + 8'd1;
    end
    assign res_data = (dp_age == 8'(LAT - 1)) ? op_data[31:0] : {24'hA5A5A5, dp_age};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: phase 0 load, 1 execute, 2 drain.
    int          phase = 0;
    int          nbytes = 0;
    int          exec_cycles = 0;
    bit          expect_start = 1'b0;
    logic [63:0] model_op = 64'd0;
    logic [8:0]  exp_out[$];
    logic [8:0]  out_log[$];
    int          out_xfers = 0;
    int          start_pulses = 0;
    logic [63:0] op_at_start = 64'd0;

    initial begin
        forever begin
            @(posedge clk);
            expect_start = 1'b0;
            if (reset) begin
                phase = 0;
                nbytes = 0;
                model_op = 64'd0;
                exp_out.delete();
            end else begin
                case (phase)
                    0: if (in_valid) begin
                        model_op[nbytes*8 +: 8] = in_data;
                        nbytes++;
                        if (nbytes == BI) begin
                            logic [7:0] x;
                            x = 8'h00;
                            nbytes = 0;
                            phase = 1;
                            exec_cycles = 0;
                            expect_start = 1'b1;
                            for (int k = 0; k < BO; k++) begin
                                exp_out.push_back({(k == N_OUT - 1), model_op[k*8 +: 8]});
                                x = x ^ model_op[k*8 +: 8];
                            end
                            if (N_OUT > BO) exp_out.push_back({1'b1, x});
                        end
                    end
                    1: begin
                        exec_cycles++;
                        if (exec_cycles == LAT) phase = 2;
                    end
                    default: if (out_ready) begin
                        out_log.push_back({out_last, out_data});
                        out_xfers++;
                        void'(exp_out.pop_front());
                        if (exp_out.size() == 0) phase = 0;
                    end
                endcase
            end
        end
    end

    // Compare process: checks every output each cycle, well clear of both clock edges.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            check("in_ready", in_ready, (!reset && phase == 0));
            check("busy", busy, (phase != 0));
            check("op_start", op_start, expect_start);
            check("out_valid", out_valid, (phase == 2));
            if (op_start) begin
                start_pulses++;
                op_at_start = op_data;
            end
            if (phase != 0) check("op_data", op_data, model_op);
            if (phase == 2 && exp_out.size() > 0) begin
                check("out_data", out_data, exp_out[0][7:0]);
                check("out_last", out_last, exp_out[0][8]);
            end
        end
    end

    // Consumer: mode 0 always ready; mode 1 stalls 5 cycles on byte 0 then toggles.
    int ready_mode = 0;
    int bp = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (ready_mode == 0) begin
                out_ready = 1'b1;
            end else if (!out_valid) begin
                bp = 0;
                out_ready = 1'b0;
            end else begin
                out_ready = (bp >= 5) ? (((bp - 5) % 2) == 0) : 1'b0;
                bp++;
            end
        end
    end

    // Called at a negedge; asserts reset for n cycles and checks the reset values.
    task automatic apply_reset(input int n);
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_op_data", op_data, 0);
        check("rst_op_start", op_start, 0);
        check("rst_busy", busy, 0);
        repeat (n - 1) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [63:0] frame, input int n, input bit gaps, input bit hold_ff);
        int  i = 0;
        int  budget = 0;
        bit  tog = 1'b0;
        bit  acc;
        while (i < n && budget < 200) begin
            @(negedge clk);
            budget++;
            tog = ~tog;
            if (gaps && !tog) begin
                in_valid = 1'b0;
                in_data = 8'hFF;
            end else begin
                in_valid = 1'b1;
                in_data = frame[i*8 +: 8];
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) i++;
        end
        if (i < n) check("send_timeout", i, n);
        @(negedge clk);
        in_valid = hold_ff;
        in_data = hold_ff ? 8'hFF : 8'h00;
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!(phase == 0 && in_ready) && c < budget);
        check("idle_timeout", (phase == 0 && in_ready), 1);
    endtask

    task automatic wait_xfers(input int target, input int budget);
        int c = 0;
        while (out_xfers < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("xfer_timeout", (out_xfers >= target), 1);
    endtask

    task automatic check_output(input string name, input logic [39:0] exp, input int n);
        check({name, "_count"}, out_log.size(), n);
        for (int k = 0; k < n && k < out_log.size(); k++) begin
            check({name, "_byte"}, out_log[k][7:0], exp[k*8 +: 8]);
            check({name, "_last"}, out_log[k][8], (k == n - 1));
        end
    endtask

    initial begin
        int base;
        int s0;
        @(negedge clk);
        apply_reset(3);

        $display("[TB] basic frame");
        out_log.delete();
        s0 = start_pulses;
        apply_stimulus(64'h0807060504030201, BI, 1'b0, 1'b0);
        wait_idle(100);
        check("basic_op", op_at_start, 64'h0807060504030201);
        check("basic_starts", start_pulses - s0, 1);
        check_output("basic", EXP_BASIC, N_OUT);

        $display("[TB] latency frame");
        out_log.delete();
        apply_stimulus(64'h11223344DEADBEEF, BI, 1'b0, 1'b0);
        wait_idle(100);
        check_output("beef", EXP_BEEF, N_OUT);

        $display("[TB] backpressure frame");
        ready_mode = 1;
        out_log.delete();
        apply_stimulus(64'h8877665544332211, BI, 1'b0, 1'b0);
        wait_idle(200);
        check_output("bp", EXP_BP, N_OUT);
        ready_mode = 0;

        $display("[TB] input gaps with 0xFF held outside load");
        out_log.delete();
        base = out_xfers;
        apply_stimulus(64'h1020304050607080, BI, 1'b1, 1'b1);
        wait_xfers(base + N_OUT - 1, 200);
        in_valid = 1'b0;
        in_data = 8'h00;
        wait_idle(100);
        check("gap_op", op_at_start, 64'h1020304050607080);
        check_output("gap", EXP_GAP, N_OUT);

        $display("[TB] reset after 5 input bytes");
        s0 = start_pulses;
        apply_stimulus(64'h0000000000CAFE77, 5, 1'b0, 1'b0);
        apply_reset(2);
        repeat (4) @(negedge clk);
        check("partial_no_start", start_pulses - s0, 0);
        out_log.delete();
        apply_stimulus(64'h0807060504030201, BI, 1'b0, 1'b0);
        wait_idle(100);
        check("rst1_op", op_at_start, 64'h0807060504030201);
        check_output("rst1", EXP_BASIC, N_OUT);

        $display("[TB] reset during drain after 2 output bytes");
        base = out_xfers;
        apply_stimulus(64'h0102030455667788, BI, 1'b0, 1'b0);
        wait_xfers(base + 2, 100);
        apply_reset(2);
        out_log.delete();
        apply_stimulus(64'h0807060504030201, BI, 1'b0, 1'b0);
        wait_idle(100);
        check_output("rst2", EXP_BASIC, N_OUT);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
